// File: rtl/bsg_astar_job_ctrl.sv
// Job sequencer for the A* engine: accepts a start/goal job, loads the cell array,
// runs the engine under a cycle budget and presents a status/cycle-count result.
module bsg_astar_job_ctrl #(
  parameter int unsigned board_width_p = 64,
  parameter int unsigned max_cycles_p  = 4096,
  localparam int unsigned cw_lp = $clog2(max_cycles_p + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              v_i,
  output logic              ready_o,
  input  logic [23:0]       start_end_point_i,
  input  logic              abort_i,
  output logic              load_o,
  output logic              astar_reset_o,
  input  logic              astar_done_i,
  output logic              v_o,
  input  logic              yumi_i,
  output logic [1:0]        status_o,
  output logic [cw_lp-1:0]  cycles_o,
  output logic [23:0]       start_end_point_o,
  output logic [15:0]       jobs_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [1:0] st_ok      = 2'b00;
  localparam logic [1:0] st_timeout = 2'b01;
  localparam logic [1:0] st_bad     = 2'b10;
  localparam logic [1:0] st_abort   = 2'b11;

  localparam logic [cw_lp-1:0] max_lp = cw_lp'(max_cycles_p);

  state_e           state;
  logic [5:0]       sx, sy, gx, gy;
  logic             bad, same;
  logic [cw_lp-1:0] cnt_inc;

  function automatic logic oob(input logic [5:0] f);
    return {26'd0, f} >= 32'(board_width_p);
  endfunction

  assign {sx, sy, gx, gy} = start_end_point_i;
  assign bad     = oob(sx) | oob(sy) | oob(gx) | oob(gy);
  assign same    = (sx == gx) && (sy == gy);
  assign cnt_inc = cycles_o + cw_lp'(1);

  // Strobes decode straight from the state register; ready is also gated by reset
  // so it drops the moment reset rises and returns the cycle it falls.
  assign ready_o       = (state == IDLE) & ~reset_i;
  assign load_o        = (state == LOAD);
  assign astar_reset_o = (state != RUN);
  assign v_o           = (state == DONE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= IDLE;
      status_o          <= st_ok;
      cycles_o          <= '0;
      start_end_point_o <= '0;
      jobs_o            <= '0;
    end else begin
      case (state)
        IDLE: if (v_i) begin
          start_end_point_o <= start_end_point_i;
          cycles_o          <= '0;
          if (bad) begin
            state    <= DONE;
            status_o <= st_bad;
          end else if (same) begin
            state    <= DONE;
            status_o <= st_ok;
          end else begin
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (abort_i) begin
            state    <= DONE;
            status_o <= st_abort;
          end else begin
            state    <= RUN;
          end
        end
        // cycles_o doubles as the run counter; its final value includes the exit cycle
        RUN: begin
          cycles_o <= cnt_inc;
          if (abort_i) begin
            state    <= DONE;
            status_o <= st_abort;
          end else if (astar_done_i) begin
            state    <= DONE;
            status_o <= st_ok;
          end else if (cnt_inc == max_lp) begin
            state    <= DONE;
            status_o <= st_timeout;
          end
        end
        DONE: if (yumi_i) begin
          state <= IDLE;
          if (jobs_o != 16'hFFFF) jobs_o <= jobs_o + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_astar_job_ctrl.sv
// Scoreboard bench for bsg_astar_job_ctrl on a 32-cell board with a 16-cycle budget.
module tb_bsg_astar_job_ctrl;
  localparam int BW = 32;
  localparam int MC = 16;
  localparam int CW = $clog2(MC + 1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          v_i = 1'b0, abort_i = 1'b0, astar_done_i = 1'b0, yumi_i = 1'b0;
  logic [23:0]   start_end_point_i = '0, start_end_point_o;
  logic          ready_o, load_o, astar_reset_o, v_o;
  logic [1:0]    status_o;
  logic [CW-1:0] cycles_o;
  logic [15:0]   jobs_o;

  always #5 clk_i = ~clk_i;

  bsg_astar_job_ctrl #(.board_width_p(BW), .max_cycles_p(MC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .start_end_point_i(start_end_point_i), .abort_i(abort_i), .load_o(load_o),
    .astar_reset_o(astar_reset_o), .astar_done_i(astar_done_i), .v_o(v_o),
    .yumi_i(yumi_i), .status_o(status_o), .cycles_o(cycles_o),
    .start_end_point_o(start_end_point_o), .jobs_o(jobs_o)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic [CW-1:0] cyc;
    logic [23:0]   sep;
    logic [7:0]    loads;
    logic [7:0]    runs;
  } exp_t;

  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  int load_cnt = 0, run_cnt = 0, jobs_exp = 0;

  always @(posedge clk_i) begin
    if (load_o) load_cnt <= load_cnt + 1;
    if (!astar_reset_o) run_cnt <= run_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pts(input int sx, sy, gx, gy);
    return {6'(sx), 6'(sy), 6'(gx), 6'(gy)};
  endfunction

  // done_at / abort_at: RUN cycle (1-based) to pulse on; abort_at 0 = LOAD; -1 = never
  task automatic job(input logic [23:0] sep, input int done_at, input int abort_at, input int hold);
    exp_t e;
    int eff, l0, r0;
    logic bad;
    bad = (int'(sep[23:18]) >= BW) || (int'(sep[17:12]) >= BW) ||
          (int'(sep[11:6]) >= BW) || (int'(sep[5:0]) >= BW);
    e = '0;
    e.sep = sep;
    if (bad) e.st = 2'b10;
    else if (sep[23:12] == sep[11:0]) e.st = 2'b00;
    else begin
      eff = (done_at >= 1 && done_at <= MC) ? done_at : MC;
      if (abort_at >= 0 && abort_at <= eff) begin
        e.st = 2'b11; e.cyc = CW'(abort_at);
      end else if (done_at >= 1 && done_at <= MC) begin
        e.st = 2'b00; e.cyc = CW'(done_at);
      end else begin
        e.st = 2'b01; e.cyc = CW'(MC);
      end
      e.loads = 8'd1;
      e.runs  = 8'(e.cyc);
    end
    q.push_back(e);
    l0 = load_cnt; r0 = run_cnt;
    chk("ready_idle", 32'(ready_o), 32'd1);
    v_i = 1'b1; start_end_point_i = sep;
    @(posedge clk_i); #1;
    v_i = 1'b0; start_end_point_i = 24'($urandom);
    for (int c = 1; c <= MC + 4 && !v_o; c++) begin
      astar_done_i = (done_at >= 0) && (c == done_at + 1);
      abort_i      = (abort_at >= 0) && (c == abort_at + 1);
      @(posedge clk_i); #1;
    end
    astar_done_i = 1'b0; abort_i = 1'b0;
    chk("v_o_done", 32'(v_o), 32'd1);
    if (v_o) begin
      e = q.pop_front();
      chk("status", 32'(status_o), 32'(e.st));
      chk("cycles", 32'(cycles_o), 32'(e.cyc));
      chk("sep", 32'(start_end_point_o), 32'(e.sep));
      chk("loads", 32'(load_cnt - l0), 32'(e.loads));
      chk("runs", 32'(run_cnt - r0), 32'(e.runs));
      chk("ready_done", 32'(ready_o), 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_i); #1;
        chk("hold_v", 32'(v_o), 32'd1);
        chk("hold_ready", 32'(ready_o), 32'd0);
        chk("hold_st", 32'(status_o), 32'(e.st));
        chk("hold_cyc", 32'(cycles_o), 32'(e.cyc));
        chk("hold_sep", 32'(start_end_point_o), 32'(e.sep));
      end
      yumi_i = 1'b1;
      @(posedge clk_i); #1;
      yumi_i = 1'b0;
      jobs_exp++;
      chk("v_o_clr", 32'(v_o), 32'd0);
      chk("ready_back", 32'(ready_o), 32'd1);
      chk("jobs", 32'(jobs_o), 32'(jobs_exp));
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_load", 32'(load_o), 32'd0);
    chk("rst_areset", 32'(astar_reset_o), 32'd1);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_status", 32'(status_o), 32'd0);
    chk("rst_cycles", 32'(cycles_o), 32'd0);
    chk("rst_sep", 32'(start_end_point_o), 32'd0);
    chk("rst_jobs", 32'(jobs_o), 32'd0);
  endtask

  initial begin
    #2 reset_i = 1'b1;
    #1 chk_reset_vals();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    #1 chk("ready_after_rst", 32'(ready_o), 32'd1);

    job(24'h041083, 10, -1, 20);            // normal job, long backpressure
    job(pts(40, 1, 2, 3), -1, -1, 0);       // bad sx
    job(pts(1, 1, 2, 32), -1, -1, 0);       // gy just past the edge
    job(pts(31, 31, 0, 0), 3, -1, 0);       // edge coordinates are legal
    job(pts(5, 7, 5, 7), -1, -1, 0);        // start == goal
    job(pts(1, 2, 3, 4), -1, -1, 2);        // timeout
    job(pts(1, 2, 3, 4), 16, -1, 0);        // done on the timeout cycle
    job(pts(1, 2, 3, 4), 5, 5, 0);          // abort beats done
    job(pts(1, 2, 3, 4), -1, 0, 0);         // abort during LOAD

    // abort and yumi in IDLE are ignored
    @(posedge clk_i); #1;
    abort_i = 1'b1; yumi_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0; yumi_i = 1'b0;
    chk("idle_abort_ready", 32'(ready_o), 32'd1);
    chk("idle_abort_v", 32'(v_o), 32'd0);
    chk("idle_yumi_jobs", 32'(jobs_o), 32'(jobs_exp));

    // reset mid-RUN
    v_i = 1'b1; start_end_point_i = 24'h041083;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    repeat (6) begin @(posedge clk_i); #1; end
    chk("midrun_areset", 32'(astar_reset_o), 32'd0);
    reset_i = 1'b1;
    #1 chk_reset_vals();
    #1 reset_i = 1'b0;
    #1 chk("ready_rel", 32'(ready_o), 32'd1);
    jobs_exp = 0;
    @(posedge clk_i); #1;
    chk("ready_rel_hold", 32'(ready_o), 32'd1);
    job(24'h041083, 2, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
